pid_ctrl_param: RTL

//  Parametrised PID motor-drive controller for the pedal-assist datapath. Sits between
//  the torque/cadence error computation and the brushless drive magnitude input.

---
 rtl/pid_ctrl_param_if.sv | 30 +++
 rtl/pid_ctrl_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pid_ctrl_param_if.sv
// pid_ctrl_param_if
//   Bundles the controller's data path signals.
//   i_error        signed control error (target - measured)
//   i_not_pedaling rider stopped: clear integrator, force drive to 0
//   i_fast_sim     shortens the sample period
//   o_drv_mag      registered, clamped unsigned drive magnitude
//   o_sample_tick  one-cycle pulse per sample instant
//   o_i_sat        integrator held at its maximum value
//   master: the error/mode source.  slave: the controller.
interface pid_ctrl_param_if #(
  parameter int ERR_W = 13,
  parameter int OUT_W = 12
);
  logic signed [ERR_W-1:0] i_error;
  logic                    i_not_pedaling;
  logic                    i_fast_sim;
  logic [OUT_W-1:0]        o_drv_mag;
  logic                    o_sample_tick;
  logic                    o_i_sat;

  modport master (
    output i_error, i_not_pedaling, i_fast_sim,
    input  o_drv_mag, o_sample_tick, o_i_sat
  );

  modport slave (
    input  i_error, i_not_pedaling, i_fast_sim,
    output o_drv_mag, o_sample_tick, o_i_sat
  );
endinterface

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param
//   PID motor-drive controller for the pedal-assist path. Combines a P term,
//   a saturating integrator (I) and a multi-sample derivative (D) evaluated at
//   a decimated sample rate, and emits a clamped unsigned drive magnitude.
// Ports
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    pid_ctrl_param_if.slave (error, not_pedaling, fast_sim in;
//          drv_mag, sample_tick, i_sat out)
module pid_ctrl_param #(
  parameter int ERR_W   = 13,
  parameter int OUT_W   = 12,
  parameter int INT_W   = 18,
  parameter int I_SHIFT = 5,
  parameter int D_DEPTH = 2,
  parameter int D_SHIFT = 2,
  parameter int DECIM_W = 20,
  parameter int FAST_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  pid_ctrl_param_if.slave   bus
);
  localparam int T_W  = ERR_W + 1;           // term width
  localparam int S_W  = T_W + 2;             // P+I+D sum width
  localparam int DS_W = ERR_W + 1 + D_SHIFT; // shifted derivative width

  localparam logic [INT_W-1:0]       INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0]       I_LIM   = INT_W'(2**(T_W-1) - 1);
  localparam logic signed [T_W-1:0]  T_MAX   = {1'b0, {(T_W-1){1'b1}}};
  localparam logic signed [T_W-1:0]  T_MIN   = {1'b1, {(T_W-1){1'b0}}};
  localparam logic signed [DS_W-1:0] D_HI    = DS_W'(2**(T_W-1) - 1);
  localparam logic signed [DS_W-1:0] D_LO    = DS_W'(-(2**(T_W-1)));
  localparam logic signed [S_W-1:0]  O_HI    = S_W'(2**OUT_W - 1);

  typedef struct packed {
    logic [T_W-1:0] p;
    logic [T_W-1:0] i;
    logic [T_W-1:0] d;
  } terms_t;

  logic [DECIM_W-1:0]            r_cnt;
  logic                          r_tick;
  logic [INT_W-1:0]              r_integ;
  logic                          r_i_sat;
  logic [D_DEPTH-1:0][ERR_W-1:0] r_hist;
  terms_t                        r_s1;
  logic [OUT_W-1:0]              r_drv_mag;

  logic                          w_tick;
  logic                          w_np;
  logic signed [ERR_W-1:0]       w_err;
  logic signed [INT_W:0]         w_sum;
  logic [INT_W-1:0]              w_integ_nxt;
  logic [INT_W-1:0]              w_ishr;
  logic signed [T_W-1:0]         w_p;
  logic signed [T_W-1:0]         w_i;
  logic signed [T_W-1:0]         w_d;
  logic signed [ERR_W:0]         w_diff;
  logic signed [DS_W-1:0]        w_dsh;
  logic signed [S_W-1:0]         w_s;
  logic [OUT_W-1:0]              w_drv;

  assign w_err = bus.i_error;
  assign w_np  = bus.i_not_pedaling;

  // Sample instant: low counter bits all ones; fast mode only looks at FAST_W bits.
  assign w_tick = bus.i_fast_sim ? (&r_cnt[FAST_W-1:0]) : (&r_cnt);

  // Integrator update in INT_W+1 signed bits so both clamps are exact.
  assign w_sum = $signed({1'b0, r_integ}) + (INT_W+1)'(w_err);

  always_comb begin
    w_integ_nxt = r_integ;
    if (w_np)
      w_integ_nxt = '0;
    else if (w_tick) begin
      if (w_sum < 0)
        w_integ_nxt = '0;
      else if (w_sum > $signed({1'b0, INT_MAX}))
        w_integ_nxt = INT_MAX;
      else
        w_integ_nxt = w_sum[INT_W-1:0];
    end
  end

  // Terms
  assign w_p    = T_W'(w_err);
  assign w_ishr = r_integ >> I_SHIFT;
  assign w_i    = (w_ishr > I_LIM) ? T_MAX : T_W'(w_ishr);

  assign w_diff = (ERR_W+1)'(w_err) - (ERR_W+1)'($signed(r_hist[D_DEPTH-1]));
  assign w_dsh  = DS_W'(w_diff) <<< D_SHIFT;
  assign w_d    = (w_dsh > D_HI) ? T_MAX :
                  (w_dsh < D_LO) ? T_MIN : w_dsh[T_W-1:0];

  // Output stage: sum of registered terms, clamped to the unsigned range.
  assign w_s = S_W'($signed(r_s1.p)) + S_W'($signed(r_s1.i)) + S_W'($signed(r_s1.d));

  always_comb begin
    w_drv = w_s[OUT_W-1:0];
    if (w_s < 0)
      w_drv = '0;
    else if (w_s > O_HI)
      w_drv = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_integ   <= '0;
      r_i_sat   <= 1'b0;
      r_hist    <= '0;
      r_s1      <= '0;
      r_drv_mag <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_tick  <= w_tick;
      r_integ <= w_integ_nxt;
      // Compared on the next value so i_sat lines up with the integrator register.
      r_i_sat <= (w_integ_nxt == INT_MAX);
      // History keeps shifting even while the rider is stopped.
      if (w_tick) begin
        for (int k = 1; k < D_DEPTH; k++)
          r_hist[k] <= r_hist[k-1];
        r_hist[0] <= w_err;
      end
      r_s1      <= '{p: w_p, i: w_i, d: w_d};
      r_drv_mag <= w_np ? '0 : w_drv;
    end
  end

  assign bus.o_drv_mag     = r_drv_mag;
  assign bus.o_sample_tick = r_tick;
  assign bus.o_i_sat       = r_i_sat;
endmodule
